divisor_seq_param: RTL and testbench

- Parametrised multi-cycle unsigned restoring divider; successor to the fixed 5-by-4 combinational divider in the ALU datapath.
- Produces both quotient and remainder, one quotient bit per clock.
- Uses a start/busy/done handshake and has an explicit divide-by-zero flag instead of silently zeroing the outputs.
- Sits behind the ALU operation decoder; the result is muxed onto the ALU output bus when done is high.

---
 rtl/divisor_seq_param.sv | 191 +++++++++++++++++++
 tb/tb_divisor_seq_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_seq_param.sv
// ----------------------------------------------------------------------------
// divisor_seq_param
//
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB
// first. A division takes WA+1 cycles from the accepted start to the done
// pulse. A zero divisor bypasses the iteration: done follows one cycle later
// with q = 0, r = 0 and div_zero = 1.
//
// Optional build macro: DIV_SIGNED_EN
//   Adds the signed_mode input, which is sampled together with start. With
//   signed_mode = 1 the operands are taken as two's complement and reduced to
//   magnitudes on capture. The quotient is negated when the operand signs
//   differ, so it truncates toward zero. The remainder takes the sign of the
//   dividend. -2^(WA-1) / -1 wraps to -2^(WA-1) and raises no flag.
//
// Parameters
//   WA : dividend and quotient width (>= 2)
//   WB : divisor and remainder width (>= 2, <= WA)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   begin a division; accepted only in IDLE or DONE
//   a   [WA]    in   dividend, captured on the accepted start
//   b   [WB]    in   divisor, captured on the accepted start
//   signed_mode in   (DIV_SIGNED_EN only) treat a and b as two's complement
//   busy        out  high while iterating
//   done        out  one-cycle pulse; q, r and div_zero are valid from here on
//   q   [WA]    out  quotient, held until the next result
//   r   [WB]    out  remainder, held until the next result
//   div_zero    out  the last accepted operation had b == 0
// ----------------------------------------------------------------------------
module divisor_seq_param #(
  parameter int WA = 5,
  parameter int WB = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
`ifdef DIV_SIGNED_EN
  input  logic          signed_mode,
`endif
  output logic          busy,
  output logic          done,
  output logic [WA-1:0] q,
  output logic [WB-1:0] r,
  output logic          div_zero
);

  localparam int CW = (WA > 1) ? $clog2(WA) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  // The dividend register shifts left once per iteration. Dividend bits leave
  // at the top, and quotient bits enter at the bottom.
  logic [WA-1:0] dvd_q,   dvd_d;
  logic [WB-1:0] dvs_q,   dvs_d;
  logic [WB:0]   part_q,  part_d;
  logic          qneg_q,  qneg_d;
  logic          rneg_q,  rneg_d;
  logic [WA-1:0] q_q,     q_d;
  logic [WB-1:0] r_q,     r_d;
  logic          dz_q,    dz_d;

  // Operand conditioning at capture time.
  logic          a_neg, b_neg;
  logic [WA-1:0] a_mag;
  logic [WB-1:0] b_mag;

`ifdef DIV_SIGNED_EN
  assign a_neg = signed_mode & a[WA-1];
  assign b_neg = signed_mode & b[WB-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  // The magnitude of the most negative value is the same bit pattern read as
  // unsigned, so the core does not need an extra bit.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One restoring step.
  logic [WB:0]   shifted, rem_next;
  logic          qbit;
  logic [WA-1:0] uq;
  logic [WB-1:0] ur;

  assign shifted  = {part_q[WB-1:0], dvd_q[WA-1]};
  assign qbit     = (shifted >= {1'b0, dvs_q});
  assign rem_next = qbit ? (shifted - {1'b0, dvs_q}) : shifted;
  assign uq       = {dvd_q[WA-2:0], qbit};
  // rem_next is always below the divisor, so its top bit is zero.
  assign ur       = rem_next[WB-1:0];

  always_comb begin
    // NOTE: every next-state signal gets a default before the case statement,
    // so no path leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (b == '0) begin
            state_d = S_DONE;
            q_d     = '0;
            r_d     = '0;
            dz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
            cnt_d   = CW'(WA - 1);
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            part_d  = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = 1'b0;
          end
        end
      end

      S_RUN: begin
        dvd_d  = uq;
        part_d = {1'b0, ur};
        if (cnt_q == '0) begin
          // The last iteration publishes the result directly. The visible
          // outputs never show a partial value.
          state_d = S_DONE;
          q_d     = qneg_q ? -uq : uq;
          r_d     = rneg_q ? -ur : ur;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the statement order.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divisor_seq_param.sv
// ----------------------------------------------------------------------------
// tb_divisor_seq_param
//
// Self-checking bench for divisor_seq_param at WA=5, WB=4. A reference model
// built from plain integer division predicts each result. Every cycle of an
// operation is checked for busy and done timing and for held outputs. The
// bench covers directed cases, start noise during busy, reset in mid-run,
// back-to-back starts and randomized operations. Build with DIV_SIGNED_EN to
// add the signed cases.
// ----------------------------------------------------------------------------
module tb_divisor_seq_param;

  localparam int WA = 5;
  localparam int WB = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
`ifdef DIV_SIGNED_EN
  logic          signed_mode;
`endif
  logic          busy;
  logic          done;
  logic [WA-1:0] q;
  logic [WB-1:0] r;
  logic          div_zero;

  divisor_seq_param #(.WA(WA), .WB(WB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
`ifdef DIV_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_zero    (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Last published result, as the model expects it to be held.
  logic [WA-1:0] held_q;
  logic [WB-1:0] held_r;
  logic          held_dz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division. SV int division truncates toward zero
  // and gives the remainder the dividend's sign, which is the signed rule.
  function automatic void model(input logic [WA-1:0] av, input logic [WB-1:0] bv,
                                input bit sm, output logic [WA-1:0] mq,
                                output logic [WB-1:0] mr, output logic mdz);
    int x, y;
    if (bv == '0) begin
      mq = '0; mr = '0; mdz = 1'b1;
    end else begin
      if (sm) begin
        x = $signed(av);
        y = $signed(bv);
      end else begin
        x = int'(av);
        y = int'(bv);
      end
      mq  = WA'(x / y);
      mr  = WB'(x % y);
      mdz = 1'b0;
    end
  endfunction

  // Call at a negedge. Issues the start and walks the operation to its done
  // cycle, checking each cycle. Returns at the negedge of the done cycle with
  // start low, so the caller can either chain another start (back-to-back) or
  // idle.
  task automatic run_op(input logic [WA-1:0] av, input logic [WB-1:0] bv,
                        input bit sm, input bit noise);
    logic [WA-1:0] mq;
    logic [WB-1:0] mr;
    logic          mdz;
    int            lat;
    model(av, bv, sm, mq, mr, mdz);
    lat   = (bv == '0) ? 1 : WA + 1;
    start = 1'b1;
    a     = av;
    b     = bv;
`ifdef DIV_SIGNED_EN
    signed_mode = sm;
`endif
    @(negedge clk);
    start = 1'b0;
    a     = WA'($urandom);
    b     = WB'($urandom);
    for (int i = 1; i <= lat; i++) begin
      if (i < lat) begin
        check("busy_run", busy, 1);
        check("done_early", done, 0);
        check("q_hold", q, held_q);
        check("r_hold", r, held_r);
        check("dz_clear", div_zero, 0);
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          a     = WA'($urandom);
          b     = WB'($urandom);
        end
        @(negedge clk);
      end else begin
        check("busy_done", busy, 0);
        check("done_pulse", done, 1);
        check("q", q, mq);
        check("r", r, mr);
        check("div_zero", div_zero, mdz);
        start = 1'b0;
      end
    end
    held_q  = mq;
    held_r  = mr;
    held_dz = mdz;
  endtask

  // One idle cycle after a done: the pulse must drop and the result must hold.
  task automatic idle_cycle();
    @(negedge clk);
    check("done_drop", done, 0);
    check("busy_idle", busy, 0);
    check("q_idle", q, held_q);
    check("r_idle", r, held_r);
    check("dz_idle", div_zero, held_dz);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef DIV_SIGNED_EN
    signed_mode = 1'b0;
`endif
    held_q  = '0;
    held_r  = '0;
    held_dz = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_dz", div_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op(5'd23, 4'd4, 1'b0, 1'b0);  idle_cycle();
    run_op(5'd31, 4'd1, 1'b0, 1'b0);  idle_cycle();
    run_op(5'd3,  4'd15, 1'b0, 1'b0); idle_cycle();
    run_op(5'd7,  4'd0, 1'b0, 1'b0);  idle_cycle();
    run_op(5'd9,  4'd3, 1'b0, 1'b0);  idle_cycle();
    // Start noise while busy must not disturb the result.
    run_op(5'd23, 4'd4, 1'b0, 1'b1);  idle_cycle();

    // Reset in mid-run: assert rst during cycle k+3, so the reset edge is k+4.
    start = 1'b1; a = 5'd23; b = 4'd4;
    @(negedge clk);                    // cycle k+1
    start = 1'b0;
    @(negedge clk);                    // cycle k+2
    @(negedge clk);                    // cycle k+3
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_dz", div_zero, 0);
    rst = 1'b0;
    held_q = '0; held_r = '0; held_dz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_nodone", done, 0);
      check("midrst_nobusy", busy, 0);
    end

    // Back-to-back: each start is issued in the previous done cycle.
    run_op(5'd23, 4'd4, 1'b0, 1'b0);
    run_op(5'd30, 4'd7, 1'b0, 1'b0);
    run_op(5'd12, 4'd0, 1'b0, 1'b0);
    run_op(5'd17, 4'd5, 1'b0, 1'b0);
    idle_cycle();

`ifdef DIV_SIGNED_EN
    run_op(5'b11001, 4'd2,    1'b1, 1'b0); idle_cycle();
    run_op(5'b10000, 4'b1111, 1'b1, 1'b0); idle_cycle();
    run_op(5'd7,     4'b1110, 1'b1, 1'b0); idle_cycle();
    // signed_mode = 0 keeps the unsigned meaning of the same bit patterns.
    run_op(5'b11001, 4'b1110, 1'b0, 1'b0); idle_cycle();
`endif

    // Randomized operations, mixing noise, zero divisors and chaining.
    for (int n = 0; n < 80; n++) begin
      logic [WA-1:0] ra;
      logic [WB-1:0] rb;
      bit            rsm;
      ra  = WA'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : WB'($urandom);
`ifdef DIV_SIGNED_EN
      rsm = 1'($urandom_range(0, 1));
`else
      rsm = 1'b0;
`endif
      run_op(ra, rb, rsm, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
